// File: rtl/pa_stream_if.sv
// Read-channel bundle between pa_stream_server and the processing-array controller.
// The server drives rdy and the head word; the controller answers with acq.
interface pa_stream_if #(
    parameter int DW = 32
);
    logic          weight_rd_rdy;
    logic          weight_rd_acq;
    logic          data_rd_rdy;
    logic          data_rd_acq;
    logic [DW-1:0] rd_data;

    modport master (
        output weight_rd_rdy,
        output data_rd_rdy,
        output rd_data,
        input  weight_rd_acq,
        input  data_rd_acq
    );

    modport slave (
        input  weight_rd_rdy,
        input  data_rd_rdy,
        input  rd_data,
        output weight_rd_acq,
        output data_rd_acq
    );
endinterface

// File: rtl/pa_stream_server.sv
// Streams a contiguous SRAM word range into a show-ahead FIFO and serves it on the weight or data channel.
// Optional abort input is built in when PA_STREAM_ABORT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing SRAM reads and serving beats until all words are accepted
// DONE   | one-cycle done pulse, then back to IDLE
module pa_stream_server #(
    parameter int AW    = 13,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          counter_rst_n,
    input  logic          start_i,
    input  logic          chan_sel_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [31:0]   length_i,
    output logic          mem_rd_en_o,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [DW-1:0] mem_rd_data_i,
`ifdef PA_STREAM_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          busy_o,
    output logic          done_o,
    pa_stream_if.master   rd_if
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            chan_q, chan_d;
    logic [AW-1:0]   base_q, base_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     issued_q, issued_d;
    logic [31:0]     accepted_q, accepted_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   fifo_q [DEPTH];

    logic [CW-1:0]   occ;
    logic            rd_en;
    logic            rdy;
    logic            acq_sel;
    logic            beat;
    logic            fifo_we;

    always_ff @(posedge clk or negedge counter_rst_n) begin
        if (!counter_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // FIFO slots already committed include the read still in flight from the SRAM
        occ        = count_q + CW'(inflight_q);
        rd_en      = (state_q == ST_STREAM) && (issued_q < len_q) && (occ < CW'(DEPTH));
        rdy        = (state_q == ST_STREAM) && (count_q != '0);
        acq_sel    = chan_q ? rd_if.data_rd_acq : rd_if.weight_rd_acq;
        beat       = rdy && acq_sel;
        fifo_we    = inflight_q;
        inflight_d = rd_en;

        if (rd_en) begin
            issued_d = issued_q + 32'd1;
        end
        if (beat) begin
            accepted_d = accepted_q + 32'd1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end
        if (fifo_we) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({fifo_we, beat})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    chan_d     = chan_sel_i;
                    base_d     = base_addr_i;
                    len_d      = length_i;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (length_i == 32'd0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accepted_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PA_STREAM_ABORT_EN
        // Abort wins over a same-cycle beat; the FIFO and any in-flight read are dropped
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
            fifo_we    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge counter_rst_n) begin
        if (!counter_rst_n) begin
            chan_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            chan_q     <= chan_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (fifo_we) begin
                fifo_q[wr_ptr_q] <= mem_rd_data_i;
            end
        end
    end

    assign mem_rd_en_o         = rd_en;
    assign mem_rd_addr_o       = rd_en ? (base_q + issued_q[AW-1:0]) : '0;
    assign rd_if.weight_rd_rdy = rdy && !chan_q;
    assign rd_if.data_rd_rdy   = rdy && chan_q;
    assign rd_if.rd_data       = fifo_q[rd_ptr_q];
    assign busy_o              = (state_q != ST_IDLE);
    assign done_o              = (state_q == ST_DONE);

endmodule

// File: tb/tb_pa_stream_server.sv
// Directed bench for pa_stream_server: a behavioural SRAM returns C0DE0000|addr one cycle after each read.
// Abort scenario is exercised when PA_STREAM_ABORT_EN is defined.
module tb_pa_stream_server;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          counter_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          chan_sel = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   length = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          busy;
    logic          done;
`ifdef PA_STREAM_ABORT_EN
    logic          abort = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    pa_stream_if #(.DW(DW)) rd_if ();

    pa_stream_server #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .counter_rst_n (counter_rst_n),
        .start_i       (start),
        .chan_sel_i    (chan_sel),
        .base_addr_i   (base_addr),
        .length_i      (length),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
`ifdef PA_STREAM_ABORT_EN
        .abort_i       (abort),
`endif
        .busy_o        (busy),
        .done_o        (done),
        .rd_if         (rd_if)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {19'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_val(mem_rd_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start during the current cycle T; returns in cycle T+1.
    task automatic start_stream(input logic [AW-1:0] b, input logic [31:0] n, input logic ch);
        base_addr = b;
        length    = n;
        chan_sel  = ch;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        counter_rst_n = 1'b0;
        rd_if.weight_rd_acq = 1'b0;
        rd_if.data_rd_acq   = 1'b0;
        step();
        step();
        vectors++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", mem_rd_en); end
        vectors++; if (mem_rd_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_rd_addr); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (rd_if.weight_rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_wrdy got %b want 0", rd_if.weight_rd_rdy); end
        vectors++; if (rd_if.data_rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_drdy got %b want 0", rd_if.data_rd_rdy); end
        vectors++; if (rd_if.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_if.rd_data); end
        counter_rst_n = 1'b1;
        step();
    endtask

    task automatic test_data_stream();
        logic [AW-1:0] ea;
        logic          exp_rdy;
        rd_if.data_rd_acq = 1'b1;
        start_stream(13'h010, 32'd8, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            vectors++; if (mem_rd_en !== (c <= 8)) begin errors++; $display("FAIL ds_en c=%0d got %b want %b", c, mem_rd_en, (c <= 8)); end
            if (c <= 8) begin
                ea = 13'h010 + 13'(c - 1);
                vectors++; if (mem_rd_addr !== ea) begin errors++; $display("FAIL ds_addr c=%0d got %h want %h", c, mem_rd_addr, ea); end
            end
            exp_rdy = (c >= 3) && (c <= 10);
            vectors++; if (rd_if.data_rd_rdy !== exp_rdy) begin errors++; $display("FAIL ds_rdy c=%0d got %b want %b", c, rd_if.data_rd_rdy, exp_rdy); end
            if (exp_rdy) begin
                ea = 13'h010 + 13'(c - 3);
                vectors++; if (rd_if.rd_data !== mem_val(ea)) begin errors++; $display("FAIL ds_data c=%0d got %h want %h", c, rd_if.rd_data, mem_val(ea)); end
            end
            vectors++; if (rd_if.weight_rd_rdy !== 1'b0) begin errors++; $display("FAIL ds_wrdy c=%0d got %b want 0", c, rd_if.weight_rd_rdy); end
            vectors++; if (done !== (c == 11)) begin errors++; $display("FAIL ds_done c=%0d got %b want %b", c, done, (c == 11)); end
            vectors++; if (busy !== (c <= 11)) begin errors++; $display("FAIL ds_busy c=%0d got %b want %b", c, busy, (c <= 11)); end
            step();
        end
        rd_if.data_rd_acq = 1'b0;
    endtask

    task automatic test_zero_length();
        start_stream(13'h123, 32'd0, 1'b1);
        vectors++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL zl_en1 got %b want 0", mem_rd_en); end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL zl_done1 got %b want 1", done); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL zl_busy1 got %b want 1", busy); end
        vectors++; if (rd_if.data_rd_rdy !== 1'b0) begin errors++; $display("FAIL zl_rdy got %b want 0", rd_if.data_rd_rdy); end
        step();
        vectors++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL zl_en2 got %b want 0", mem_rd_en); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL zl_done2 got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zl_busy2 got %b want 0", busy); end
    endtask

    task automatic test_weight_backpressure();
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int   beats = 0;
        int   issued = 0;
        logic seen_done = 1'b0;
        start_stream(13'h100, 32'd6, 1'b0);
        for (int c = 0; c < 60 && !seen_done; c++) begin
            rd_if.weight_rd_acq = pat[c % 6];
            vectors++; if (rd_if.data_rd_rdy !== 1'b0) begin errors++; $display("FAIL bp_drdy c=%0d got %b want 0", c, rd_if.data_rd_rdy); end
            if (mem_rd_en === 1'b1) issued++;
            vectors++; if (issued - beats > DEPTH) begin errors++; $display("FAIL bp_occupancy c=%0d got %0d want <=%0d", c, issued - beats, DEPTH); end
            if (rd_if.weight_rd_rdy === 1'b1) begin
                vectors++; if (rd_if.rd_data !== mem_val(13'h100 + 13'(beats))) begin errors++; $display("FAIL bp_data beat=%0d got %h want %h", beats, rd_if.rd_data, mem_val(13'h100 + 13'(beats))); end
                if (rd_if.weight_rd_acq) beats++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            step();
        end
        rd_if.weight_rd_acq = 1'b0;
        vectors++; if (!seen_done) begin errors++; $display("FAIL bp_done_timeout got 0 want 1"); end
        vectors++; if (beats != 6) begin errors++; $display("FAIL bp_beats got %0d want 6", beats); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        int   ni = 0;
        int   beats = 0;
        logic seen_done = 1'b0;
        rd_if.data_rd_acq = 1'b1;
        start_stream(13'h1FFE, 32'd4, 1'b1);
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (mem_rd_en === 1'b1) begin
                if (ni < 4) begin
                    vectors++; if (mem_rd_addr !== exp_addr[ni]) begin errors++; $display("FAIL wr_addr i=%0d got %h want %h", ni, mem_rd_addr, exp_addr[ni]); end
                end
                ni++;
            end
            if (rd_if.data_rd_rdy === 1'b1) begin
                if (beats < 4) begin
                    vectors++; if (rd_if.rd_data !== mem_val(exp_addr[beats])) begin errors++; $display("FAIL wr_data beat=%0d got %h want %h", beats, rd_if.rd_data, mem_val(exp_addr[beats])); end
                end
                beats++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            step();
        end
        rd_if.data_rd_acq = 1'b0;
        vectors++; if (ni != 4) begin errors++; $display("FAIL wr_reads got %0d want 4", ni); end
        vectors++; if (beats != 4) begin errors++; $display("FAIL wr_beats got %0d want 4", beats); end
        vectors++; if (!seen_done) begin errors++; $display("FAIL wr_done_timeout got 0 want 1"); end
    endtask

    task automatic test_restart_and_reset();
        int   beats = 0;
        logic seen_done = 1'b0;
        rd_if.data_rd_acq   = 1'b0;
        rd_if.weight_rd_acq = 1'b0;
        start_stream(13'h020, 32'd8, 1'b1);
        repeat (4) step();
        start_stream(13'h300, 32'd2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy c=%0d got %b want 1", c, busy); end
            vectors++; if (rd_if.data_rd_rdy !== 1'b1) begin errors++; $display("FAIL rs_drdy c=%0d got %b want 1", c, rd_if.data_rd_rdy); end
            vectors++; if (rd_if.weight_rd_rdy !== 1'b0) begin errors++; $display("FAIL rs_wrdy c=%0d got %b want 0", c, rd_if.weight_rd_rdy); end
            vectors++; if (rd_if.rd_data !== mem_val(13'h020)) begin errors++; $display("FAIL rs_head c=%0d got %h want %h", c, rd_if.rd_data, mem_val(13'h020)); end
            step();
        end
        #2;
        counter_rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
        vectors++; if (rd_if.data_rd_rdy !== 1'b0) begin errors++; $display("FAIL ar_drdy got %b want 0", rd_if.data_rd_rdy); end
        vectors++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL ar_en got %b want 0", mem_rd_en); end
        vectors++; if (rd_if.rd_data !== '0) begin errors++; $display("FAIL ar_data got %h want 0", rd_if.rd_data); end
        step();
        counter_rst_n = 1'b1;
        step();
        rd_if.data_rd_acq = 1'b1;
        start_stream(13'h040, 32'd3, 1'b1);
        for (int c = 0; c < 15 && !seen_done; c++) begin
            vectors++; if (rd_if.weight_rd_rdy !== 1'b0) begin errors++; $display("FAIL pr_wrdy c=%0d got %b want 0", c, rd_if.weight_rd_rdy); end
            if (rd_if.data_rd_rdy === 1'b1) begin
                vectors++; if (rd_if.rd_data !== mem_val(13'h040 + 13'(beats))) begin errors++; $display("FAIL pr_data beat=%0d got %h want %h", beats, rd_if.rd_data, mem_val(13'h040 + 13'(beats))); end
                beats++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            step();
        end
        rd_if.data_rd_acq = 1'b0;
        vectors++; if (beats != 3) begin errors++; $display("FAIL pr_beats got %0d want 3", beats); end
        vectors++; if (!seen_done) begin errors++; $display("FAIL pr_done_timeout got 0 want 1"); end
    endtask

`ifdef PA_STREAM_ABORT_EN
    task automatic test_abort();
        int   beats = 0;
        logic seen_done = 1'b0;
        rd_if.data_rd_acq = 1'b1;
        start_stream(13'h050, 32'd10, 1'b1);
        for (int c = 0; c < 20 && beats < 3; c++) begin
            if (rd_if.data_rd_rdy === 1'b1) begin
                vectors++; if (rd_if.rd_data !== mem_val(13'h050 + 13'(beats))) begin errors++; $display("FAIL ab_data beat=%0d got %h want %h", beats, rd_if.rd_data, mem_val(13'h050 + 13'(beats))); end
                beats++;
            end
            step();
        end
        vectors++; if (rd_if.data_rd_rdy !== 1'b1) begin errors++; $display("FAIL ab_rdy_pre got %b want 1", rd_if.data_rd_rdy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++; if (rd_if.data_rd_rdy !== 1'b0) begin errors++; $display("FAIL ab_rdy_post got %b want 0", rd_if.data_rd_rdy); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done1 got %b want 0", done); end
        step();
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done2 got %b want 0", done); end
        vectors++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL ab_en got %b want 0", mem_rd_en); end
        beats = 0;
        start_stream(13'h060, 32'd2, 1'b1);
        for (int c = 0; c < 15 && !seen_done; c++) begin
            if (rd_if.data_rd_rdy === 1'b1) begin
                vectors++; if (rd_if.rd_data !== mem_val(13'h060 + 13'(beats))) begin errors++; $display("FAIL ab_new_data beat=%0d got %h want %h", beats, rd_if.rd_data, mem_val(13'h060 + 13'(beats))); end
                beats++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            step();
        end
        rd_if.data_rd_acq = 1'b0;
        vectors++; if (beats != 2) begin errors++; $display("FAIL ab_new_beats got %0d want 2", beats); end
        vectors++; if (!seen_done) begin errors++; $display("FAIL ab_new_done_timeout got 0 want 1"); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_stream();
        test_zero_length();
        test_weight_backpressure();
        test_wrap();
        test_restart_and_reset();
`ifdef PA_STREAM_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pa_stream_server.md
Name: pa_stream_server

Overview:
- Memory-side responder for the processing-array controller's read channels: serves the weight read stream and the data read stream over the rdy/acq handshake.
- On a start pulse, prefetches a contiguous word range from the on-chip SRAM (1-cycle read latency) into a small show-ahead FIFO.
- Presents words to the controller on the selected channel.
- Drops rdy when the range is exhausted; the controller treats rdy low as end-of-stream.

Parameters:
- AW, 13, SRAM word-address width.
- DW, 32, data word width.
- DEPTH, 4, prefetch FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock.
- counter_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches chan_sel, base_addr, length.
- chan_sel  in  1  0 = weight channel, 1 = data channel.
- base_addr  in  AW  first SRAM word address.
- length  in  32  number of words to stream.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  AW  SRAM read address.
- mem_rd_data  in  DW  SRAM read data, valid the cycle after mem_rd_en.
- weight_rd_rdy  out  1  word available on the weight channel.
- weight_rd_acq  in  1  controller accepts on the weight channel.
- data_rd_rdy  out  1  word available on the data channel.
- data_rd_acq  in  1  controller accepts on the data channel.
- rd_data  out  DW  FIFO head word.
- busy  out  1  high from the accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset (counter_rst_n low, async): all outputs 0, FIFO empty, state IDLE, all counters 0.
- States:
  - IDLE: start → STREAM; latch inputs, issued = accepted = 0. If length == 0 → DONE instead (no SRAM reads).
  - STREAM: when accepted == length → DONE.
  - DONE: done = 1 for exactly one cycle → IDLE.
- start is ignored unless the state is IDLE.
- Issue rule (STREAM only): mem_rd_en = (issued < length) && (fifo_count + inflight < DEPTH).
  - mem_rd_addr = base + issued, modulo 2^AW (wraps silently).
  - inflight is 1 bit: registered mem_rd_en.
- Fill: the cycle after mem_rd_en, mem_rd_data is written to the FIFO tail.
- Beat: selected rdy && selected acq.
  - Pops the head; accepted increments.
  - Push and pop in the same cycle are both allowed; count is unchanged.
- Channel rdy:
  - Selected rdy = (state == STREAM) && FIFO non-empty.
  - Non-selected rdy is always 0; its acq is ignored.
- rd_data is the FIFO head (show-ahead); it holds while rdy && !acq.
- Latency: start at cycle T → first mem_rd_en at T+1 → data in FIFO at T+2 → rdy high at T+3.
- Throughput: with acq held high, 1 beat/cycle sustained.
- The FIFO can never overflow, by the issue rule. A pop is never attempted when empty: rdy gates the pop.
- Last beat at cycle N: rdy low at N+1; state DONE with done = 1 at N+1; busy low at N+2.
- busy = (state != IDLE).

Optional Feature:
- Macro: PA_STREAM_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - abort high in STREAM or DONE: next cycle state = IDLE, FIFO flushed, in-flight read discarded, both rdy low, no done pulse.
  - abort has priority over a same-cycle beat; that beat still counts as consumed by the controller.
- Without the macro: no abort port, and a stream can only end by completion or reset.

Test Plan:
- base = 0x010, length = 8, data channel, data_rd_acq held high → 8 beats on consecutive cycles, rd_data = mem[0x010..0x017], done pulse at the cycle after the 8th beat, weight_rd_rdy stays 0.
- length = 0, start → no mem_rd_en, done at T+1, busy high for exactly one cycle.
- Weight channel, length = 6, acq toggled 1,0,0,1,1,0… → rd_data stable while acq is low; FIFO count never exceeds DEPTH = 4; order mem[base..base+5] preserved.
- base = 0x1FFE (AW = 13), length = 4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- start pulsed again mid-stream, and counter_rst_n dropped mid-stream → the second start is ignored; reset clears all outputs immediately and the next start streams cleanly from its own base.
- With PA_STREAM_ABORT_EN defined: abort after 3 beats of length 10 → rdy low the next cycle, no done, FIFO empty, a new start is accepted.
